// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick-driven interval timer.
package tick_timer_pkg;

  localparam int unsigned TT_WIDTH_DEFAULT = 8;

  // Codes 2'b10 and 2'b11 are unused and fall back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } tt_state_t;

endpackage : tick_timer_pkg

// File: rtl/tick_timer_if.sv
// Control/status bundle between the timer and the logic that arms it.
interface tick_timer_if
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TT_WIDTH_DEFAULT
);

  logic             tick;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] period;
  logic             auto_reload;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             done;

  modport master (
    output tick, start, stop, period, auto_reload,
    input  busy, count, done
  );

  modport slave (
    input  tick, start, stop, period, auto_reload,
    output busy, count, done
  );

endinterface : tick_timer_if

// File: rtl/tick_timer.sv
// Interval timer: counts upstream ticks up to a latched period, pulses done,
// then either stops (one-shot) or restarts the interval (auto-reload).
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TT_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  tick_timer_if.slave   bus
);

  tt_state_t        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_reload;
  logic             r_done;
  logic             r_busy;

  tt_state_t        w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_period_nxt;
  logic             w_reload_nxt;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic             w_terminal;
  logic             w_start_ok;

  // Latched period is never zero while running, so the subtraction cannot underflow.
  assign w_terminal = bus.tick && (r_count == (r_period - WIDTH'(1)));
  assign w_start_ok = bus.start && (bus.period != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_reload <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_period <= w_period_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Priority within a cycle: stop, terminal tick, plain tick, start.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!bus.stop && w_start_ok) begin
          w_period_nxt = bus.period;
          w_reload_nxt = bus.auto_reload;
          w_count_nxt  = '0;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_terminal) begin
          w_done_nxt  = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = r_reload ? ST_RUN : ST_IDLE;
        end else if (bus.tick) begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  assign bus.busy  = r_busy;
  assign bus.count = r_count;
  assign bus.done  = r_done;

endmodule : tick_timer

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer with hand-computed expected outputs.
module tb_tick_timer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  tick_timer_if #(.WIDTH(WIDTH)) bus ();

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int unsigned busy, input int unsigned cnt,
                      input int unsigned done);
    check({tag, ".busy"},  32'(bus.busy),  busy);
    check({tag, ".count"}, 32'(bus.count), cnt);
    check({tag, ".done"},  32'(bus.done),  done);
  endtask

  task automatic arm(input int unsigned per, input logic ar);
    bus.start       = 1'b1;
    bus.period      = WIDTH'(per);
    bus.auto_reload = ar;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    rst             = 1'b1;
    bus.tick        = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.period      = '0;
    bus.auto_reload = 1'b0;
    step();
    outs("reset", 0, 0, 0);
    rst = 1'b0;

    // Reset in the middle of an interval
    arm(10, 1'b0);
    outs("rst_run.arm", 1, 0, 0);
    bus.tick = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    outs("rst_run.cnt3", 1, 3, 0);
    rst = 1'b1;
    step();
    outs("rst_run.after", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    outs("rst_run.idle", 0, 0, 0);
    bus.tick = 1'b0;

    // One-shot, period 5, tick every 4th cycle
    arm(5, 1'b0);
    outs("os.arm", 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check("os.hold_done", 32'(bus.done), 0);
      end
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      if (k < 5) outs("os.step", 1, 32'(k), 0);
      else       outs("os.end", 0, 0, 1);
    end
    bus.tick = 1'b1;
    step();
    outs("os.after", 0, 0, 0);
    step();
    outs("os.after2", 0, 0, 0);
    bus.tick = 1'b0;

    // Auto-reload, period 3, tick every cycle
    arm(3, 1'b1);
    outs("ar.arm", 1, 0, 0);
    bus.tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      outs("ar.cyc", 1, 32'(c % 3), (c % 3 == 0) ? 1 : 0);
    end
    bus.tick = 1'b0;
    bus.stop = 1'b1;
    step();
    outs("ar.stop", 0, 0, 0);
    bus.stop = 1'b0;

    // Stop coincident with the terminal tick
    arm(2, 1'b0);
    bus.tick = 1'b1;
    step();
    outs("stopterm.cnt1", 1, 1, 0);
    bus.stop = 1'b1;
    step();
    outs("stopterm.hit", 0, 0, 0);
    bus.stop = 1'b0;
    bus.tick = 1'b0;
    step();
    outs("stopterm.after", 0, 0, 0);

    // Zero period is refused
    bus.start  = 1'b1;
    bus.period = '0;
    step();
    outs("p0.a", 0, 0, 0);
    step();
    outs("p0.b", 0, 0, 0);
    bus.start = 1'b0;

    // Period change while running does not affect the interval
    arm(4, 1'b0);
    bus.period = WIDTH'(9);
    bus.tick   = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    outs("pchg.cnt3", 1, 3, 0);
    step();
    outs("pchg.end", 0, 0, 1);
    bus.tick = 1'b0;
    step();
    outs("pchg.after", 0, 0, 0);

    // Period 1 in auto-reload: done every cycle
    arm(1, 1'b1);
    bus.tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      outs("p1.cyc", 1, 0, 1);
    end
    bus.tick = 1'b0;
    bus.stop = 1'b1;
    step();
    outs("p1.stop", 0, 0, 0);
    bus.stop = 1'b0;

    // Maximum period, no wrap
    arm(255, 1'b0);
    bus.tick = 1'b1;
    for (int i = 1; i <= 254; i++) begin
      step();
      if (bus.count != WIDTH'(i) || bus.done != 1'b0)
        check("p255.walk", 32'(bus.count), 32'(i));
    end
    outs("p255.cnt254", 1, 254, 0);
    step();
    outs("p255.end", 0, 0, 1);
    bus.tick = 1'b0;
    step();
    outs("p255.after", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tick_timer
